dtree_feature_loader: RTL and testbench
=======================================

// Module: dtree_feature_loader
// PURPOSE
// - Front/back end for the combinational decision-tree classifiers.
// - Receives a byte-serial feature frame (valid/ready + last) and assembles the feature vector.
// - Holds the vector stable on feat_vec for an external tree. After a settle period, captures the tree's class_in.
// - Presents the class on a valid/ready result port and counts classified frames.
// PARAMETERS
// - NUM_FEAT   5   features per frame (one byte each)
// - FEAT_W     8   feature width, bits; equals stream byte width
// - CLASS_W    5   class label width
// - SETTLE_CYC 1   cycles feat_vec is held before class_in is sampled (>=1)
// - CNT_W      16  width of frame_cnt
// PORTS
// - clk        in   1                  rising-edge clock; the only clock
// - rst        in   1                  reset, asynchronous, active-high
// - s_valid    in   1                  stream byte valid
// - s_data     in   FEAT_W             stream byte
// - s_last     in   1                  marks final byte of frame
// - s_ready    out  1                  block accepts a byte
// - feat_vec   out  NUM_FEAT*FEAT_W    feature i at [i*FEAT_W +: FEAT_W]; drives tree inputs
// - class_in   in   CLASS_W            tree output (combinational from feat_vec)
// - m_valid    out  1                  result valid
// - m_class    out  CLASS_W            captured class label
// - m_ready    in   1                  result consumer ready
// - frame_err  out  1                  one-cycle pulse: malformed frame dropped
// - frame_cnt  out  CNT_W              frames delivered; wraps all-ones -> 0
// BEHAVIOUR
// - Reset values: s_ready=0 while rst is asserted and 1 after release; feat_vec, m_valid, m_class, frame_err, frame_cnt are 0. State=COLLECT, idx=0.
// - Byte transfer = s_valid & s_ready. The first byte of a frame is feature 0.
// - COLLECT: s_ready=1. Each byte goes into a shadow register at idx, then idx++.
//   - Byte at idx=FRAME_LEN-1 with s_last: the frame is good. Copy shadow to feat_vec on the next edge and go to EVAL.
//   - s_last with idx<FRAME_LEN-1: drop the frame. Pulse frame_err, idx=0, stay in COLLECT. feat_vec is unchanged.
//   - Byte at idx=FRAME_LEN-1 without s_last: drop the frame. Pulse frame_err and go to SKIP.
// - SKIP: s_ready=1. Discard bytes until a byte with s_last is accepted, then go to COLLECT with idx=0.
// - EVAL: s_ready=0. Hold feat_vec for SETTLE_CYC cycles. On the last of them, register class_in into m_class and set m_valid=1. Go to RESULT.
//   - Latency: last byte accepted at edge T. feat_vec updates at T+1. m_valid rises at T+1+SETTLE_CYC.
// - RESULT: s_ready=0. m_valid and m_class stay stable until m_valid&m_ready.
//   - On handshake: m_valid=0, frame_cnt++ (wraps), state=COLLECT. s_ready=1 in the cycle after the handshake.
// - feat_vec changes only on a good frame; it holds through EVAL, RESULT and later bad frames.
// - FRAME_LEN = NUM_FEAT, or NUM_FEAT+1 when the checksum option is compiled in.
// - Asserting rst mid-frame or mid-result aborts everything immediately. No frame_err is generated for it.
// CONFIGURATION
// - FRAME_CHECKSUM_EN defined: each frame carries one extra trailing byte, the XOR of all feature bytes.
//   - On the last byte, compare it with the running XOR.
//   - Mismatch: drop the frame, pulse frame_err, keep feat_vec, return to COLLECT.
//   - The checksum byte never appears in feat_vec.
// - FRAME_CHECKSUM_EN undefined: FRAME_LEN=NUM_FEAT. No XOR logic is present.
// TESTING
// - Reset: assert rst after 2 bytes of a frame -> m_valid=0, feat_vec=0, frame_cnt=0. s_ready=1 the cycle after release. The next full frame is processed normally.
// - Good frame: 0x10,0x20,0x30,0x40,0x50 (s_last on 5th), stub class_in=5'd17 -> feat_vec=0x5040302010. m_valid at T+2 (SETTLE_CYC=1), m_class=17, frame_cnt=1 after handshake.
// - Backpressure: hold m_ready=0 for 10 cycles after m_valid -> m_valid/m_class stable, s_ready=0, offered bytes not accepted. Raise m_ready -> s_ready=1 next cycle.
// - Early last: s_last on 3rd byte -> one frame_err pulse, no m_valid, feat_vec unchanged. The following good frame gives the correct result.
// - Missing last: 7 bytes, s_last on 7th -> frame_err on 5th byte. Bytes 6-7 are swallowed in SKIP. The next frame is good.
// - Wrap + checksum: preload frame_cnt to 0xFFFF and deliver a frame -> 0x0000.
// - With FRAME_CHECKSUM_EN: the same 5 bytes plus 0x10 -> accepted. The same 5 bytes plus 0x11 -> frame_err, no m_valid.

Source files
------------

// File: rtl/dtree_feature_loader.sv
// dtree_feature_loader: byte-serial feature frame loader and result port for a
// combinational decision-tree classifier.
// Optional build macro: FRAME_CHECKSUM_EN (trailing XOR checksum byte per frame).
module dtree_feature_loader #(
  parameter int unsigned NUM_FEAT   = 5,
  parameter int unsigned FEAT_W     = 8,
  parameter int unsigned CLASS_W    = 5,
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  input  logic [FEAT_W-1:0]          s_data,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic [NUM_FEAT*FEAT_W-1:0] feat_vec,
  input  logic [CLASS_W-1:0]         class_in,
  output logic                       m_valid,
  output logic [CLASS_W-1:0]         m_class,
  input  logic                       m_ready,
  output logic                       frame_err,
  output logic [CNT_W-1:0]           frame_cnt
);

`ifdef FRAME_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = NUM_FEAT + 1;
`else
  localparam int unsigned FRAME_LEN = NUM_FEAT;
`endif
  localparam int unsigned IDX_W = (FRAME_LEN < 2) ? 1 : $clog2(FRAME_LEN);
  localparam int unsigned SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_SKIP,
    ST_EVAL,
    ST_RESULT
  } state_t;

  state_t                       state_q;
  logic [IDX_W-1:0]             idx_q;
  logic [SET_W-1:0]             settle_q;
  logic [NUM_FEAT*FEAT_W-1:0]   shadow_q;
  logic [NUM_FEAT*FEAT_W-1:0]   shadow_d;
  logic [NUM_FEAT*FEAT_W-1:0]   feat_vec_q;
  logic                         s_ready_q;
  logic                         m_valid_q;
  logic [CLASS_W-1:0]           m_class_q;
  logic                         frame_err_q;
  logic [CNT_W-1:0]             frame_cnt_q;
  logic                         byte_fire;
`ifdef FRAME_CHECKSUM_EN
  logic [FEAT_W-1:0]            xor_q;
  logic [FEAT_W-1:0]            xor_d;
`endif

  // s_ready is held low during reset and rises as soon as reset is released.
  assign s_ready   = s_ready_q & ~rst;
  assign byte_fire = s_valid & s_ready;

  assign feat_vec  = feat_vec_q;
  assign m_valid   = m_valid_q;
  assign m_class   = m_class_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

  // Merge the incoming byte into the shadow vector at the current feature slot.
  always_comb begin
    shadow_d = shadow_q;
    for (int unsigned i = 0; i < NUM_FEAT; i++) begin
      if (idx_q == IDX_W'(i)) begin
        shadow_d[i*FEAT_W +: FEAT_W] = s_data;
      end
    end
  end

`ifdef FRAME_CHECKSUM_EN
  // Running XOR of feature bytes, restarted on the first byte of each frame.
  always_comb begin
    xor_d = (idx_q == '0) ? s_data : (xor_q ^ s_data);
  end
`endif

  // Frame collection, evaluation and result handshake state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      idx_q       <= '0;
      settle_q    <= '0;
      shadow_q    <= '0;
      feat_vec_q  <= '0;
      s_ready_q   <= 1'b1;
      m_valid_q   <= 1'b0;
      m_class_q   <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
`ifdef FRAME_CHECKSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        ST_COLLECT: begin
          s_ready_q <= 1'b1;
          if (byte_fire) begin
            shadow_q <= shadow_d;
`ifdef FRAME_CHECKSUM_EN
            xor_q    <= xor_d;
`endif
            if (idx_q == LAST_IDX) begin
              idx_q <= '0;
              if (!s_last) begin
                frame_err_q <= 1'b1;
                state_q     <= ST_SKIP;
`ifdef FRAME_CHECKSUM_EN
              end else if (s_data != xor_q) begin
                frame_err_q <= 1'b1;
`endif
              end else begin
                settle_q  <= '0;
                s_ready_q <= 1'b0;
                state_q   <= ST_EVAL;
              end
            end else if (s_last) begin
              frame_err_q <= 1'b1;
              idx_q       <= '0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end

        ST_SKIP: begin
          s_ready_q <= 1'b1;
          if (byte_fire && s_last) begin
            idx_q   <= '0;
            state_q <= ST_COLLECT;
          end
        end

        ST_EVAL: begin
          s_ready_q <= 1'b0;
          if (settle_q == '0) begin
            feat_vec_q <= shadow_q;
          end
          if (settle_q == SET_W'(SETTLE_CYC)) begin
            m_class_q <= class_in;
            m_valid_q <= 1'b1;
            state_q   <= ST_RESULT;
          end else begin
            settle_q <= settle_q + SET_W'(1);
          end
        end

        ST_RESULT: begin
          s_ready_q <= 1'b0;
          if (m_ready) begin
            m_valid_q   <= 1'b0;
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            idx_q       <= '0;
            s_ready_q   <= 1'b1;
            state_q     <= ST_COLLECT;
          end
        end

        default: begin
          idx_q     <= '0;
          s_ready_q <= 1'b1;
          state_q   <= ST_COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Testbench for dtree_feature_loader: table-driven frames plus directed
// sequences for backpressure, SKIP recovery, checksum, reset and counter wrap.
module tb_dtree_feature_loader;

`ifdef FRAME_CHECKSUM_EN
  localparam int unsigned FL  = 6;
  localparam bit          CKS = 1'b1;
`else
  localparam int unsigned FL  = 5;
  localparam bit          CKS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_ready;

  logic        s_ready,   s_ready_w;
  logic [39:0] feat_vec,  feat_vec_w;
  logic [4:0]  class_in,  class_in_w;
  logic        m_valid,   m_valid_w;
  logic [4:0]  m_class,   m_class_w;
  logic        frame_err, frame_err_w;
  logic [15:0] frame_cnt;
  logic [1:0]  frame_cnt_w;

  int unsigned ncmp = 0;
  int unsigned nerr = 0;
  int unsigned err_seen = 0;
  int unsigned exp_cnt = 0;
  logic [39:0] last_feat = '0;

  always #5 clk = ~clk;

  // Stub tree: class = (sum of feature bytes + 1) mod 32.
  function automatic logic [4:0] tree(input logic [39:0] f);
    logic [10:0] s;
    s = 11'd1;
    for (int i = 0; i < 5; i++) s = s + 11'(f[i*8 +: 8]);
    return s[4:0];
  endfunction

  assign class_in   = tree(feat_vec);
  assign class_in_w = tree(feat_vec_w);

  dtree_feature_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .feat_vec(feat_vec), .class_in(class_in),
    .m_valid(m_valid), .m_class(m_class), .m_ready(m_ready),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  // Second instance with a 2-bit counter, fed identically, exercises wrap.
  dtree_feature_loader #(.CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready_w), .feat_vec(feat_vec_w), .class_in(class_in_w),
    .m_valid(m_valid_w), .m_class(m_class_w), .m_ready(m_ready),
    .frame_err(frame_err_w), .frame_cnt(frame_cnt_w)
  );

  always @(negedge clk) if (frame_err) err_seen++;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge following acceptance.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int unsigned w = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (s_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("send_ready", 64'(s_ready), 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] bytes, input int unsigned n,
                            input bit add_cks, input logic [7:0] flip);
    logic [7:0] x = '0;
    for (int unsigned i = 0; i < n; i++) begin
      x = x ^ bytes[i*8 +: 8];
      send_byte(bytes[i*8 +: 8], (i == n - 1) && !add_cks);
    end
    if (add_cks) send_byte(x ^ flip, 1'b1);
  endtask

  // Checks latency after a good frame, holds the result for 'hold' cycles while
  // offering a byte, then handshakes and checks both counters.
  task automatic deliver(input logic [39:0] feat, input logic [4:0] cls, input int unsigned hold);
    check("lat_T0_mvalid", 64'(m_valid), 64'd0);
    @(negedge clk);
    check("lat_T1_mvalid", 64'(m_valid), 64'd0);
    check("lat_T1_sready", 64'(s_ready), 64'd0);
    check("feat_vec", 64'(feat_vec), 64'(feat));
    @(negedge clk);
    check("lat_T2_mvalid", 64'(m_valid), 64'd1);
    check("m_class", 64'(m_class), 64'(cls));
    for (int unsigned k = 0; k < hold; k++) begin
      s_valid = 1'b1;
      s_data  = 8'h99;
      s_last  = 1'b1;
      @(negedge clk);
      check("bp_mvalid", 64'(m_valid), 64'd1);
      check("bp_mclass", 64'(m_class), 64'(cls));
      check("bp_sready", 64'(s_ready), 64'd0);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    exp_cnt++;
    last_feat = feat;
    check("hs_mvalid", 64'(m_valid), 64'd0);
    check("hs_sready", 64'(s_ready), 64'd1);
    check("frame_cnt", 64'(frame_cnt), 64'(exp_cnt[15:0]));
    check("frame_cnt_wrap", 64'(frame_cnt_w), 64'(exp_cnt[1:0]));
  endtask

  task automatic expect_drop(input string nm, input int unsigned e0);
    repeat (3) @(negedge clk);
    check({nm, "_err_pulses"}, 64'(err_seen - e0), 64'd1);
    check({nm, "_mvalid"}, 64'(m_valid), 64'd0);
    check({nm, "_feat_kept"}, 64'(feat_vec), 64'(last_feat));
    check({nm, "_sready"}, 64'(s_ready), 64'd1);
  endtask

  typedef struct {
    int unsigned n;
    logic [63:0] bytes;
    bit          ok;
    logic [39:0] feat;
    logic [4:0]  cls;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int unsigned e0;

    tbl[0] = '{n: 5, bytes: 64'h50_40_30_20_10, ok: 1'b1, feat: 40'h50_40_30_20_10, cls: 5'd17};
    tbl[1] = '{n: 3, bytes: 64'h03_02_01,       ok: 1'b0, feat: 40'h0,              cls: 5'd0};
    tbl[2] = '{n: 5, bytes: 64'hFF_FF_FF_FF_FF, ok: 1'b1, feat: 40'hFF_FF_FF_FF_FF, cls: 5'd28};
    tbl[3] = '{n: 1, bytes: 64'h7E,             ok: 1'b0, feat: 40'h0,              cls: 5'd0};
    tbl[4] = '{n: 4, bytes: 64'h04_03_02_01,    ok: 1'b0, feat: 40'h0,              cls: 5'd0};
    tbl[5] = '{n: 5, bytes: 64'h05_04_03_02_01, ok: 1'b1, feat: 40'h05_04_03_02_01, cls: 5'd16};
    tbl[6] = '{n: 5, bytes: 64'h50_40_30_20_10, ok: 1'b1, feat: 40'h50_40_30_20_10, cls: 5'd17};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sready", 64'(s_ready), 64'd0);
    check("rst_mvalid", 64'(m_valid), 64'd0);
    check("rst_feat", 64'(feat_vec), 64'd0);
    check("rst_mclass", 64'(m_class), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_sready", 64'(s_ready), 64'd1);

    // Table-driven frames: good ones plus early-last drops.
    for (int t = 0; t < 7; t++) begin
      e0 = err_seen;
      send_frame(tbl[t].bytes, tbl[t].n, CKS && tbl[t].ok, 8'h00);
      if (tbl[t].ok) deliver(tbl[t].feat, tbl[t].cls, 0);
      else expect_drop("early_last", e0);
    end

    // Backpressure: result held 10 cycles while a byte is offered.
    send_frame(tbl[5].bytes, 5, CKS, 8'h00);
    deliver(tbl[5].feat, tbl[5].cls, 10);
    send_frame(tbl[0].bytes, 5, CKS, 8'h00);
    deliver(tbl[0].feat, tbl[0].cls, 0);

    // Missing last: 7 bytes, s_last on 7th; error on byte FL, rest swallowed.
    e0 = err_seen;
    for (int unsigned i = 0; i < 7; i++) begin
      send_byte(8'(8'hA0 + i), i == 6);
      if (i == FL - 1) check("missing_last_err_pulse", 64'(frame_err), 64'd1);
    end
    expect_drop("missing_last", e0);
    send_frame(tbl[2].bytes, 5, CKS, 8'h00);
    deliver(tbl[2].feat, tbl[2].cls, 0);

`ifdef FRAME_CHECKSUM_EN
    // Bad checksum: 0x11 instead of 0x10.
    e0 = err_seen;
    send_frame(tbl[0].bytes, 5, 1'b1, 8'h01);
    expect_drop("bad_cks", e0);
    send_frame(tbl[0].bytes, 5, 1'b1, 8'h00);
    deliver(tbl[0].feat, tbl[0].cls, 0);
`endif

    // Reset after two bytes of a frame.
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    e0 = err_seen;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_mvalid", 64'(m_valid), 64'd0);
    check("midrst_feat", 64'(feat_vec), 64'd0);
    check("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("midrst_sready", 64'(s_ready), 64'd0);
    rst = 1'b0;
    exp_cnt = 0;
    last_feat = '0;
    @(negedge clk);
    check("midrst_rel_sready", 64'(s_ready), 64'd1);
    check("midrst_no_err", 64'(err_seen - e0), 64'd0);
    send_frame(tbl[0].bytes, 5, CKS, 8'h00);
    deliver(tbl[0].feat, tbl[0].cls, 0);

    // Reset while a result is pending.
    send_frame(tbl[2].bytes, 5, CKS, 8'h00);
    repeat (2) @(negedge clk);
    check("pre_rst_mvalid", 64'(m_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("resrst_mvalid", 64'(m_valid), 64'd0);
    check("resrst_frame_cnt", 64'(frame_cnt), 64'd0);
    rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk);

    // Five more frames: 2-bit counter wraps 3 -> 0 -> 1.
    for (int k = 0; k < 5; k++) begin
      send_frame(tbl[5].bytes, 5, CKS, 8'h00);
      deliver(tbl[5].feat, tbl[5].cls, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
